// File: rtl/ct_spsram_8192x32_ctrl.sv
// ct_spsram_8192x32_ctrl: valid/ready request front-end for the 8192x32 single-port SRAM macro
// Turns a read/write request stream into SRAM pin activity and buffers read data in a
// small response FIFO so the consumer can apply backpressure.
// Ports:
//   forever_cpuclk, cpurst_b          clock (also the SRAM clock), async active-low reset
//   req_vld/req_rdy/req_wr/req_addr/req_wdata/req_bmask   request channel
//   rsp_vld/rsp_rdy/rsp_data          in-order read response channel
//   init_done                         high once the controller is running
//   sram_a/cen/gwen/wen/d, sram_q     SRAM macro pins (CEN/GWEN/WEN active low)
// Build option: define CT_SPSRAM_CTRL_INIT_EN to zero-fill the whole array after reset.
module ct_spsram_8192x32_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    req_vld,
  output logic                    req_rdy,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_bmask,
  output logic                    rsp_vld,
  input  logic                    rsp_rdy,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   sram_a,
  output logic                    sram_cen,
  output logic                    sram_gwen,
  output logic [DATA_WIDTH-1:0]   sram_wen,
  output logic [DATA_WIDTH-1:0]   sram_d,
  input  logic [DATA_WIDTH-1:0]   sram_q
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd2;
  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  run;
  logic                  accept;
  logic                  wr_acc;
  logic                  pop;
  logic                  rd_pend;
  logic                  rd_room;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           occ;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] bm_exp;
  logic                  init_act;
  logic [ADDR_WIDTH-1:0] init_a;
`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam logic [1:0] INIT = 2'd1;
  logic [ADDR_WIDTH-1:0] init_cnt;
  assign init_act  = state == INIT;
  assign init_a    = init_cnt;
  assign state_nxt = state == IDLE ? INIT : init_act ? (&init_cnt ? RUN : INIT) : RUN;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) init_cnt <= '0;
    else if (init_act) init_cnt <= init_cnt + 1'b1;
`else
  assign init_act  = 1'b0;
  assign init_a    = '0;
  assign state_nxt = RUN;
`endif
  assign run       = state == RUN;
  assign init_done = run;
  assign pop       = rsp_vld & rsp_rdy;
  // Reads are admitted only if the entry they will eventually occupy is guaranteed free,
  // counting the read already in flight and the pop happening this cycle.
  assign occ       = {1'b0, fifo_cnt} + (CW+1)'(rd_pend) - (CW+1)'(pop);
  assign rd_room   = occ < (CW+1)'(RSP_DEPTH);
  assign req_rdy   = run & (req_wr | rd_room);
  assign accept    = req_vld & req_rdy;
  assign wr_acc    = accept & req_wr;
  assign rsp_vld   = fifo_cnt != '0;
  assign rsp_data  = fifo_mem[rd_ptr];
  always_comb begin
    bm_exp = '0;
    for (int i = 0; i < BW; i++) bm_exp[8*i +: 8] = {8{req_bmask[i]}};
  end
  assign sram_cen  = init_act ? 1'b0 : ~accept;
  assign sram_a    = init_act ? init_a : req_addr;
  assign sram_gwen = init_act ? 1'b0 : ~wr_acc;
  assign sram_wen  = init_act ? '0 : wr_acc ? ~bm_exp : '1;
  assign sram_d    = init_act ? '0 : req_wdata;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      state    <= IDLE;
      rd_pend  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rd_pend  <= accept & ~req_wr;
      wr_ptr   <= rd_pend ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + 1'b1 : rd_ptr;
      fifo_cnt <= fifo_cnt + CW'(rd_pend) - CW'(pop);
    end
  // SRAM Q is valid the cycle after the read access, i.e. while rd_pend is high.
  always_ff @(posedge forever_cpuclk)
    if (rd_pend) fifo_mem[wr_ptr] <= sram_q;
endmodule

// File: tb/tb_ct_spsram_8192x32_ctrl.sv
// tb_ct_spsram_8192x32_ctrl: directed self-checking bench with a behavioural SRAM model
module tb_ct_spsram_8192x32_ctrl;
`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam int INIT_CYC = 8194;
`else
  localparam int INIT_CYC = 2;
`endif
  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_vld, req_rdy, req_wr;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_bmask;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_data;
  logic        init_done;
  logic [12:0] sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d, sram_q;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mem [8192];
  bit          seen [8192];
  logic [31:0] exp_q [$];
  always #5 clk = ~clk;
  ct_spsram_8192x32_ctrl dut (
    .forever_cpuclk(clk), .cpurst_b(rst_b),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bmask(req_bmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );
  // Unwritten words read back as A5A5A5A5 so a missing zero-fill is visible.
  always @(posedge clk)
    if (!sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a]  <= ((seen[sram_a] ? mem[sram_a] : 32'hA5A5A5A5) & sram_wen) | (sram_d & ~sram_wen);
        seen[sram_a] <= 1'b1;
      end else sram_q <= seen[sram_a] ? mem[sram_a] : 32'hA5A5A5A5;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic wr, input logic [12:0] a, input logic [31:0] d, input logic [3:0] bm);
    int n;
    @(negedge clk);
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_bmask = bm;
    #1;
    n = 0;
    while (!req_rdy && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n == 20) chk("rdy_timeout", 32'd0, 32'd1);
  endtask
  task automatic wr(input string tag, input logic [12:0] a, input logic [31:0] d, input logic [3:0] bm, input logic [31:0] exp_wen);
    issue(1'b1, a, d, bm);
    chk({tag, "_cen"}, 32'(sram_cen), 32'd0);
    chk({tag, "_gwen"}, 32'(sram_gwen), 32'd0);
    chk({tag, "_wen"}, sram_wen, exp_wen);
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [12:0] a, input logic [31:0] exp);
    issue(1'b0, a, 32'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    #1 chk({tag, "_lat1"}, 32'(rsp_vld), 32'd0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, 32'(rsp_vld), 32'd1);
    chk({tag, "_data"}, rsp_data, exp);
  endtask
  task automatic release_and_wait(input string tag);
    int k;
    @(negedge clk);
    rst_b = 1'b1;
    req_vld = 1'b1; req_wr = 1'b0;
    #1;
    chk({tag, "_idle_rdy"}, 32'(req_rdy), 32'd0);
    chk({tag, "_idle_cen"}, 32'(sram_cen), 32'd1);
    chk({tag, "_idle_done"}, 32'(init_done), 32'd0);
    req_vld = 1'b0;
    k = 0;
    while (k < 10000 && !init_done) begin
      @(negedge clk); #1; k++;
`ifdef CT_SPSRAM_CTRL_INIT_EN
      if (k == 1) begin
        chk({tag, "_init_a0"}, 32'(sram_a), 32'd0);
        chk({tag, "_init_cen"}, 32'(sram_cen), 32'd0);
        chk({tag, "_init_gwen"}, 32'(sram_gwen), 32'd0);
        chk({tag, "_init_wen"}, sram_wen, 32'd0);
        chk({tag, "_init_d"}, sram_d, 32'd0);
        chk({tag, "_init_rdy"}, 32'(req_rdy), 32'd0);
      end
      if (k == 2) chk({tag, "_init_a1"}, 32'(sram_a), 32'd1);
`endif
      if (k <= 12 && rsp_vld) chk({tag, "_stale_rsp"}, 32'(rsp_vld), 32'd0);
    end
    chk({tag, "_init_cycle"}, 32'(k + 1), 32'(INIT_CYC));
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, nresp;
    bit acc, all_rdy;
    logic [31:0] wd;
    rst_b = 1'b0; rsp_rdy = 1'b1;
    req_vld = 1'b1; req_wr = 1'b1; req_addr = '0; req_wdata = '0; req_bmask = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_gwen", 32'(sram_gwen), 32'd1);
    chk("rst_wen", sram_wen, 32'hFFFFFFFF);
    req_vld = 1'b0;
    release_and_wait("t1");
`ifndef CT_SPSRAM_CTRL_INIT_EN
    wr("t1w", 13'h1FFF, 32'd0, 4'hF, 32'h0);
`endif
    rd_chk("t1r", 13'h1FFF, 32'h00000000);
    wr("t2w", 13'h0010, 32'hDEADBEEF, 4'hF, 32'h0);
    rd_chk("t2r", 13'h0010, 32'hDEADBEEF);
    wr("t3w", 13'h0010, 32'h11223344, 4'b0101, 32'hFF00FF00);
    rd_chk("t3r", 13'h0010, 32'hDE22BE44);
    wr("bm0w", 13'h0010, 32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF);
    rd_chk("bm0r", 13'h0010, 32'hDE22BE44);
    for (int i = 0; i < 4; i++) wr("t4w", 13'h20 + 13'(i), 32'hC0DE0000 + i, 4'hF, 32'h0);
    k = 0; nresp = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rsp_rdy = c >= 4;
      req_vld = k < 4; req_wr = 1'b0; req_addr = 13'h20 + 13'(k);
      #1;
      if (c < 4) chk("t4_rdy", 32'(req_rdy), 32'(c < 2));
      if (rsp_vld && rsp_rdy) begin
        chk("t4_data", rsp_data, 32'hC0DE0000 + nresp);
        nresp++;
      end
      acc = req_vld & req_rdy;
      @(posedge clk);
      if (acc) k++;
    end
    req_vld = 1'b0;
    chk("t4_count", 32'(nresp), 32'd4);
    chk("t4_empty", 32'(rsp_vld), 32'd0);
    issue(1'b0, 13'h0010, 32'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0; req_vld = 1'b0;
    #1 chk("t5_rst_rsp", 32'(rsp_vld), 32'd0);
    repeat (2) @(negedge clk);
    release_and_wait("t5");
    all_rdy = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (rsp_vld) all_rdy = 1'b0;
    end
    chk("t5_no_rsp", 32'(all_rdy), 32'd1);
    rsp_rdy = 1'b1; nresp = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      wd = 32'h5A000000 ^ (32'(c / 2) * 32'h00010203);
      req_vld = c < 100; req_wr = ~c[0]; req_addr = 13'h100 + 13'(c / 2);
      req_wdata = wd; req_bmask = 4'hF;
      if (c < 100 && c[0]) exp_q.push_back(wd);
      #1;
      if (c < 100 && !req_rdy) all_rdy = 1'b0;
      if (rsp_vld) begin
        if (exp_q.size() == 0) chk("t6_extra", rsp_data, 32'hXXXXXXXX);
        else chk("t6_data", rsp_data, exp_q.pop_front());
        nresp++;
      end
      @(posedge clk);
    end
    req_vld = 1'b0;
    chk("t6_rdy", 32'(all_rdy), 32'd1);
    chk("t6_count", 32'(nresp), 32'd50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
